// File: rtl/gain_integrator.sv
// Loop-filter stage of the amplitude control loop: saturating 32-bit gain integrator
// with lock detection. Define GAIN_LEAK_EN to build the leaky-integrator variant.
module gain_integrator #(
    parameter logic [31:0] GAIN_INIT  = 32'h2000_0000,
    parameter logic [31:0] ACC_MAX    = 32'h7FFF_FFFF,
    parameter logic [31:0] LOCK_THR   = 32'd64,
    parameter int unsigned LOCK_CNT   = 8
`ifdef GAIN_LEAK_EN
    ,
    parameter int unsigned LEAK_SHIFT = 12
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] eps_i,
    input  logic               valid_i,
    input  logic               hold_i,
    input  logic               clear_i,
    output logic signed [15:0] gain_o,
    output logic               valid_o,
    output logic               sat_o,
    output logic               lock_o
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    localparam logic [7:0] LOCK_CNT_W = LOCK_CNT[7:0];

    logic [31:0]        acc_q, acc_d;
    logic               valid_q, valid_d;
    logic               sat_q, sat_d;
    logic               lock_q, lock_d;
    lock_state_e        state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;

    logic signed [32:0] sum;
    logic [31:0]        abs_eps;
    logic               inthr;
    logic               lock_eval;

    // NOTE: every variable driven in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        sum = $signed({acc_q[31], acc_q}) + $signed({eps_i[31], eps_i});
`ifdef GAIN_LEAK_EN
        sum = sum - ($signed({acc_q[31], acc_q}) >>> LEAK_SHIFT);
`endif

        // -2^31 has no positive twin; it saturates to the largest magnitude instead.
        abs_eps = eps_i;
        if (eps_i[31]) begin
            if (eps_i == 32'sh8000_0000) begin
                abs_eps = 32'h7FFF_FFFF;
            end else begin
                abs_eps = -eps_i;
            end
        end
        inthr     = (abs_eps <= LOCK_THR);
        lock_eval = valid_i & ~clear_i;
    end

    always_comb begin
        acc_d   = acc_q;
        valid_d = 1'b0;
        sat_d   = 1'b0;
        if (clear_i) begin
            acc_d   = GAIN_INIT;
            valid_d = 1'b1;
        end else if (valid_i) begin
            valid_d = 1'b1;
            if (!hold_i) begin
                if (sum[32]) begin
                    acc_d = '0;
                    sat_d = 1'b1;
                end else if (sum > $signed({1'b0, ACC_MAX})) begin
                    acc_d = ACC_MAX;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum[31:0];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = UNLOCKED;
            cnt_d   = 8'd0;
        end else if (lock_eval) begin
            case (state_q)
                UNLOCKED: begin
                    if (inthr) begin
                        cnt_d   = 8'd1;
                        state_d = (LOCK_CNT_W == 8'd1) ? LOCKED : LOCKING;
                    end
                end
                LOCKING: begin
                    if (inthr) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == LOCK_CNT_W) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (!inthr) begin
                        cnt_d   = 8'd0;
                        state_d = UNLOCKED;
                    end
                end
                default: begin
                    cnt_d   = 8'd0;
                    state_d = UNLOCKED;
                end
            endcase
        end
        lock_d = (state_d == LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= GAIN_INIT;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            lock_q  <= 1'b0;
            state_q <= UNLOCKED;
            cnt_q   <= 8'd0;
        end else begin
            acc_q   <= acc_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            lock_q  <= lock_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gain_o  = acc_q[31:16];
    assign valid_o = valid_q;
    assign sat_o   = sat_q;
    assign lock_o  = lock_q;

endmodule

// File: doc/gain_integrator.md
Name: gain_integrator

Overview:
- Loop-filter stage of the amplitude control loop. Sits directly downstream of the error stage and consumes its scaled error word (eps, kp already applied as a sign-extended shift) with its valid strobe.
- Integrates eps into a 32-bit gain accumulator, saturates it to a non-negative range, and outputs a 16-bit gain to the multiplier stage.
- Also reports loop lock status and saturation events.

Parameters:
- GAIN_INIT, 32'h2000_0000, accumulator value after reset / clear (gain_o = 16'h2000).
- ACC_MAX, 32'h7FFF_FFFF, upper clamp of accumulator (must be >= 0).
- LOCK_THR, 32'd64, |eps| threshold for an in-lock sample.
- LOCK_CNT, 8, consecutive in-threshold samples required to declare lock (1..255).
- LEAK_SHIFT, 12, leak divisor exponent (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- eps_i  in  32 signed  scaled error from the error stage
- valid_i  in  1  eps_i qualifier, single-cycle strobe, may be asserted every cycle
- hold_i  in  1  freeze accumulator (lock evaluation continues)
- clear_i  in  1  reload accumulator with GAIN_INIT, reset lock FSM
- gain_o  out  16 signed  acc[31:16], Q1.15 gain
- valid_o  out  1  gain_o updated strobe
- sat_o  out  1  one-cycle pulse: last update clamped
- lock_o  out  1  high while FSM in LOCKED

Behaviour:
- Reset (rst=1 at a clk edge):
  - acc = GAIN_INIT, gain_o = GAIN_INIT[31:16], valid_o = 0, sat_o = 0, lock_o = 0.
  - FSM = UNLOCKED, lock counter = 0.
  - rst overrides all other inputs, including mid-lock and mid-stream.
- Update (valid_i=1, hold_i=0, clear_i=0):
  - sum = sign-extended 33-bit acc + eps_i.
  - sum < 0 → acc = 0, sat_o = 1.
  - sum > ACC_MAX → acc = ACC_MAX, sat_o = 1.
  - Otherwise acc = sum[31:0], sat_o = 0.
  - gain_o and valid_o are registered: 1-cycle latency from valid_i to valid_o. valid_o is high exactly one cycle per accepted sample. Back-to-back samples are accepted with no bubbles.
- Hold:
  - valid_i=1 with hold_i=1 → acc unchanged, valid_o = 1 (gain_o repeats its value), sat_o = 0.
- Clear:
  - clear_i=1 → acc = GAIN_INIT, FSM = UNLOCKED, counter = 0, valid_o = 1, sat_o = 0.
  - clear_i has priority over valid_i and hold_i. The eps_i present in that cycle is discarded.
- valid_i=0 → acc held, valid_o = 0, sat_o = 0.
- Lock evaluation:
  - Runs on every valid_i=1 cycle without clear_i, whether or not hold_i is set.
  - absval = |eps_i|; -2^31 maps to 2^31-1.
  - inthr = (absval <= LOCK_THR).
- Lock FSM (8-bit counter):
  - UNLOCKED: inthr → counter = 1, go to LOCKING (go directly to LOCKED if LOCK_CNT = 1). !inthr → stay.
  - LOCKING: inthr → counter += 1; when counter reaches LOCK_CNT, go to LOCKED. !inthr → counter = 0, go to UNLOCKED.
  - LOCKED: !inthr → counter = 0, go to UNLOCKED. inthr → stay.
  - lock_o is registered and equals (state == LOCKED). It rises in the same cycle as valid_o for the LOCK_CNT-th consecutive in-threshold sample.
- Saturation does not affect the FSM.

Optional Feature:
- Macro: GAIN_LEAK_EN.
- Defined: on an update, the leak term is computed as sum = acc + eps_i - (acc >>> LEAK_SHIFT) (33-bit, then the same clamp as above). This makes the integrator leaky so gain decays toward 0 at zero error. Hold and clear behave as without the macro.
- Undefined: pure integrator. LEAK_SHIFT is unused and no leak logic is synthesized.

Test Plan:
- Reset, then eps_i=32'h0001_0000 with valid_i for 1 cycle → next cycle valid_o=1, gain_o=16'h2001, sat_o=0.
- Preload via 3 samples to acc=32'h7FFF_0000, then eps_i=32'h0002_0000 → acc=32'h7FFF_FFFF, gain_o=16'h7FFF, sat_o=1 for one cycle.
- acc=32'h0000_8000, eps_i=32'hFFFF_0000 → gain_o=16'h0000, sat_o=1; a following eps_i=0 gives sat_o=0.
- LOCK_THR=64, LOCK_CNT=8: seven samples of eps_i=10 → lock_o=0; eighth sample → lock_o=1 with its valid_o. Next sample eps_i=-65 → lock_o=0.
- hold_i=1 with eps_i=32'h0100_0000 for 4 samples → gain_o constant, valid_o pulses 4 times. Then clear_i=1 together with valid_i → gain_o=16'h2000, lock_o=0.
- rst asserted while LOCKED and mid-stream → next cycle gain_o=16'h2000, valid_o=0, lock_o=0. With GAIN_LEAK_EN, LEAK_SHIFT=12, eps_i=0 from acc=32'h2000_0000 → acc=32'h1FFE_0000.
